// File: rtl/wb_rr_grant.sv
// Round-robin picker: first requester after last_idx_i, wrapping.
// Purely combinational; the caller registers the result.
module wb_rr_grant #(
  parameter int N  = 2,
  parameter int MW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [MW-1:0] last_idx_i,
  output logic [MW-1:0] pick_idx_o,
  output logic          pick_vld_o
);

  // Scan from the farthest candidate back to the nearest so the
  // nearest requester after last_idx_i is the one left standing.
  always_comb begin
    pick_idx_o = '0;
    pick_vld_o = 1'b0;
    for (int k = N; k >= 1; k--) begin
      int idx;
      idx = (int'(last_idx_i) + k) % N;
      if (req_i[idx]) begin
        pick_vld_o = 1'b1;
        pick_idx_o = MW'(idx);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Wishbone B3 N-to-1 round-robin arbiter.
// Grant is registered and held for the whole CYC of the winner.
module wb_arbiter_rr #(
  parameter int num_masters = 2,
  parameter int aw          = 32,
  parameter int dw          = 32
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [num_masters*aw-1:0]   wbm_adr_i,
  input  logic [num_masters*dw-1:0]   wbm_dat_i,
  input  logic [num_masters*dw/8-1:0] wbm_sel_i,
  input  logic [num_masters-1:0]      wbm_we_i,
  input  logic [num_masters-1:0]      wbm_cyc_i,
  input  logic [num_masters-1:0]      wbm_stb_i,
  input  logic [num_masters*3-1:0]    wbm_cti_i,
  input  logic [num_masters*2-1:0]    wbm_bte_i,
  output logic [num_masters*dw-1:0]   wbm_dat_o,
  output logic [num_masters-1:0]      wbm_ack_o,
  output logic [num_masters-1:0]      wbm_err_o,
  output logic [num_masters-1:0]      wbm_rty_o,
  output logic [aw-1:0]               wbs_adr_o,
  output logic [dw-1:0]               wbs_dat_o,
  output logic [dw/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  input  logic [dw-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i
);

  function automatic int idx_width(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int mw = idx_width(num_masters);
  localparam int sw = dw / 8;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [mw-1:0] gnt_idx_q, gnt_idx_d;
  logic [mw-1:0] last_idx_q, last_idx_d;
  logic [mw-1:0] pick_idx;
  logic          pick_vld;
  logic          gnt_vld;

  wb_rr_grant #(
    .N  (num_masters),
    .MW (mw)
  ) u_grant (
    .req_i      (wbm_cyc_i),
    .last_idx_i (last_idx_q),
    .pick_idx_o (pick_idx),
    .pick_vld_o (pick_vld)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      gnt_idx_q  <= '0;
      last_idx_q <= mw'(num_masters - 1);
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_idx_q <= last_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    last_idx_d = last_idx_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d    = GRANTED;
          gnt_idx_d  = pick_idx;
          last_idx_d = pick_idx;
        end
      end
      GRANTED: begin
        if (!wbm_cyc_i[gnt_idx_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_vld = (state_q == GRANTED);

  // Data-path fields follow gnt_idx even when idle, so they stay deterministic.
  assign wbs_adr_o = wbm_adr_i[gnt_idx_q*aw +: aw];
  assign wbs_dat_o = wbm_dat_i[gnt_idx_q*dw +: dw];
  assign wbs_sel_o = wbm_sel_i[gnt_idx_q*sw +: sw];
  assign wbs_cti_o = wbm_cti_i[gnt_idx_q*3 +: 3];
  assign wbs_bte_o = wbm_bte_i[gnt_idx_q*2 +: 2];
  assign wbs_we_o  = wbm_we_i[gnt_idx_q];
  assign wbs_cyc_o = gnt_vld & wbm_cyc_i[gnt_idx_q];
  assign wbs_stb_o = gnt_vld & wbm_stb_i[gnt_idx_q];

  assign wbm_dat_o = {num_masters{wbs_dat_i}};

  always_comb begin
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    for (int i = 0; i < num_masters; i++) begin
      wbm_ack_o[i] = wbs_ack_i & gnt_vld & (gnt_idx_q == mw'(i));
      wbm_err_o[i] = wbs_err_i & gnt_vld & (gnt_idx_q == mw'(i));
      wbm_rty_o[i] = wbs_rty_i & gnt_vld & (gnt_idx_q == mw'(i));
    end
  end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Bench for wb_arbiter_rr with two masters.
// Vector table for per-cycle behaviour plus directed multi-cycle sequences.
module tb_wb_arbiter_rr;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk;
  logic              rst;
  logic [NM*AW-1:0]  wbm_adr;
  logic [NM*DW-1:0]  wbm_dat;
  logic [NM*DW/8-1:0] wbm_sel;
  logic [NM-1:0]     wbm_we;
  logic [NM-1:0]     m_cyc;
  logic [NM-1:0]     m_stb;
  logic [2:0]        cti0, cti1;
  logic [NM*2-1:0]   wbm_bte;
  logic [NM*DW-1:0]  wbm_dat_o;
  logic [NM-1:0]     wbm_ack_o;
  logic [NM-1:0]     wbm_err_o;
  logic [NM-1:0]     wbm_rty_o;
  logic [AW-1:0]     wbs_adr_o;
  logic [DW-1:0]     wbs_dat_o;
  logic [DW/8-1:0]   wbs_sel_o;
  logic              wbs_we_o;
  logic              wbs_cyc_o;
  logic              wbs_stb_o;
  logic [2:0]        wbs_cti_o;
  logic [1:0]        wbs_bte_o;
  logic [DW-1:0]     wbs_dat_i;
  logic              wbs_ack_i;
  logic              wbs_err_i;
  logic              wbs_rty_i;
  logic              ack_man;
  logic              auto_ack;

  int n_cmp;
  int n_bad;

  localparam logic [31:0] ADR0 = 32'h0000_0A00;
  localparam logic [31:0] DAT0 = 32'h1111_1111;
  localparam logic [31:0] ADR1 = 32'h0000_0100;
  localparam logic [31:0] DAT1 = 32'hDEAD_BEEF;

  assign wbm_adr   = {ADR1, ADR0};
  assign wbm_dat   = {DAT1, DAT0};
  assign wbm_sel   = {4'h3, 4'hF};
  assign wbm_we    = 2'b10;
  assign wbm_bte   = {2'b01, 2'b00};
  assign wbs_ack_i = auto_ack ? (wbs_cyc_o & wbs_stb_o) : ack_man;

  wb_arbiter_rr #(
    .num_masters (NM),
    .aw          (AW),
    .dw          (DW)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbm_adr_i (wbm_adr),
    .wbm_dat_i (wbm_dat),
    .wbm_sel_i (wbm_sel),
    .wbm_we_i  (wbm_we),
    .wbm_cyc_i (m_cyc),
    .wbm_stb_i (m_stb),
    .wbm_cti_i ({cti1, cti0}),
    .wbm_bte_i (wbm_bte),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_o (wbm_ack_o),
    .wbm_err_o (wbm_err_o),
    .wbm_rty_o (wbm_rty_o),
    .wbs_adr_o (wbs_adr_o),
    .wbs_dat_o (wbs_dat_o),
    .wbs_sel_o (wbs_sel_o),
    .wbs_we_o  (wbs_we_o),
    .wbs_cyc_o (wbs_cyc_o),
    .wbs_stb_o (wbs_stb_o),
    .wbs_cti_o (wbs_cti_o),
    .wbs_bte_o (wbs_bte_o),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_i (wbs_ack_i),
    .wbs_err_i (wbs_err_i),
    .wbs_rty_i (wbs_rty_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  cyc;
    logic        ack;
    logic        err;
    logic        rty;
    logic        e_cyc;
    logic        e_stb;
    logic [1:0]  e_ack;
    logic [1:0]  e_err;
    logic [1:0]  e_rty;
    logic [31:0] e_adr;
    logic [31:0] e_dat;
  } vec_t;

  function automatic vec_t mk(
    input logic [1:0] cyc, input logic ack, input logic err,
    input logic rty, input logic e_cyc, input logic e_stb,
    input logic [1:0] e_ack, input logic [1:0] e_err,
    input logic [1:0] e_rty, input logic [31:0] e_adr,
    input logic [31:0] e_dat);
    vec_t v;
    v.cyc = cyc; v.ack = ack; v.err = err; v.rty = rty;
    v.e_cyc = e_cyc; v.e_stb = e_stb;
    v.e_ack = e_ack; v.e_err = e_err; v.e_rty = e_rty;
    v.e_adr = e_adr; v.e_dat = e_dat;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    m_cyc = '0; m_stb = '0;
    ack_man = 1'b0; auto_ack = 1'b0;
    wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs[12];
  int   done[2];
  bit   cool[2];
  int   prev;
  int   ncyc;
  int   acks0;
  int   acks1;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1;
    m_cyc = '0; m_stb = '0;
    cti0 = 3'b000; cti1 = 3'b000;
    wbs_dat_i = 32'hCAFE_F00D;
    ack_man = 1'b0; auto_ack = 1'b0;
    wbs_err_i = 1'b0; wbs_rty_i = 1'b0;

    vecs[0]  = mk(2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADR0, DAT0);
    vecs[1]  = mk(2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADR0, DAT0);
    vecs[2]  = mk(2'b10, 1, 0, 0, 1, 1, 2'b10, 2'b00, 2'b00, ADR1, DAT1);
    vecs[3]  = mk(2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADR1, DAT1);
    vecs[4]  = mk(2'b11, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADR1, DAT1);
    vecs[5]  = mk(2'b11, 1, 0, 0, 1, 1, 2'b01, 2'b00, 2'b00, ADR0, DAT0);
    vecs[6]  = mk(2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADR0, DAT0);
    vecs[7]  = mk(2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADR0, DAT0);
    vecs[8]  = mk(2'b10, 0, 1, 0, 1, 1, 2'b00, 2'b10, 2'b00, ADR1, DAT1);
    vecs[9]  = mk(2'b10, 0, 0, 1, 1, 1, 2'b00, 2'b00, 2'b10, ADR1, DAT1);
    vecs[10] = mk(2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADR1, DAT1);
    vecs[11] = mk(2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADR1, DAT1);

    // Reset state, with requests and a stray ack present.
    @(negedge clk);
    m_cyc = 2'b11; m_stb = 2'b11; ack_man = 1'b1;
    #1;
    chk("rst_cyc", wbs_cyc_o, 1'b0);
    chk("rst_stb", wbs_stb_o, 1'b0);
    chk("rst_ack", wbm_ack_o, 2'b00);
    chk("rst_adr", wbs_adr_o, ADR0);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      m_cyc = vecs[i].cyc;
      m_stb = vecs[i].cyc;
      ack_man = vecs[i].ack;
      wbs_err_i = vecs[i].err;
      wbs_rty_i = vecs[i].rty;
      #1;
      chk($sformatf("v%0d_cyc", i), wbs_cyc_o, vecs[i].e_cyc);
      chk($sformatf("v%0d_stb", i), wbs_stb_o, vecs[i].e_stb);
      chk($sformatf("v%0d_ack", i), wbm_ack_o, vecs[i].e_ack);
      chk($sformatf("v%0d_err", i), wbm_err_o, vecs[i].e_err);
      chk($sformatf("v%0d_rty", i), wbm_rty_o, vecs[i].e_rty);
      chk($sformatf("v%0d_adr", i), wbs_adr_o, vecs[i].e_adr);
      chk($sformatf("v%0d_dat", i), wbs_dat_o, vecs[i].e_dat);
      if (i == 2) begin
        chk("v2_we", wbs_we_o, 1'b1);
        chk("v2_sel", wbs_sel_o, 4'h3);
        chk("v2_bte", wbs_bte_o, 2'b01);
      end
      @(negedge clk);
    end
    chk("dat_bcast", wbm_dat_o, {2{32'hCAFE_F00D}});

    // Contention after reset plus burst hold.
    do_reset();
    m_cyc = 2'b11; m_stb = 2'b11; cti0 = 3'b010;
    #1;
    chk("cont_idle", wbs_cyc_o, 1'b0);
    acks0 = 0; acks1 = 0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      cti0 = (b == 3) ? 3'b111 : 3'b010;
      ack_man = 1'b1;
      #1;
      chk($sformatf("burst%0d_adr", b), wbs_adr_o, ADR0);
      chk($sformatf("burst%0d_cti", b), wbs_cti_o, cti0);
      if (wbm_ack_o[0]) acks0++;
      if (wbm_ack_o[1]) acks1++;
    end
    chk("burst_acks0", acks0, 4);
    chk("burst_acks1", acks1, 0);
    @(negedge clk);
    m_cyc = 2'b10; m_stb = 2'b10; ack_man = 1'b0; cti0 = 3'b000;
    #1;
    chk("rel_cyc", wbs_cyc_o, 1'b0);
    @(negedge clk);
    #1;
    chk("dead_cyc", wbs_cyc_o, 1'b0);
    @(negedge clk);
    #1;
    chk("m1_cyc", wbs_cyc_o, 1'b1);
    chk("m1_adr", wbs_adr_o, ADR1);

    // Fairness: 100 back-to-back single reads per master.
    do_reset();
    auto_ack = 1'b1;
    done[0] = 0; done[1] = 0;
    cool[0] = 0; cool[1] = 0;
    prev = -1; ncyc = 0;
    while ((done[0] < 100 || done[1] < 100) && ncyc < 2000) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        m_cyc[i] = (done[i] < 100) && !cool[i];
        m_stb[i] = m_cyc[i];
        cool[i] = 1'b0;
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        if (wbm_ack_o[i]) begin
          if (prev < 0) chk("fair_first", i, 0);
          else chk("fair_alt", i, prev ^ 1);
          prev = i;
          done[i]++;
          cool[i] = 1'b1;
        end
      end
      ncyc++;
    end
    chk("fair_timeout", (ncyc < 2000), 1'b1);
    chk("fair_done0", done[0], 100);
    chk("fair_done1", done[1], 100);
    auto_ack = 1'b0;

    // Async reset while master 1 is granted.
    do_reset();
    m_cyc = 2'b10; m_stb = 2'b10;
    @(negedge clk);
    ack_man = 1'b1;
    #1;
    chk("pre_rst_cyc", wbs_cyc_o, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_cyc", wbs_cyc_o, 1'b0);
    chk("arst_ack", wbm_ack_o, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    ack_man = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b11;
    @(negedge clk);
    ack_man = 1'b1;
    #1;
    chk("post_rst_adr", wbs_adr_o, ADR0);
    chk("post_rst_ack", wbm_ack_o, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_rr.md
Name: wb_arbiter_rr

Overview:
- Wishbone B3 N-to-1 arbiter: several masters share one slave port. It is the mirror of wb_mux, which fans one master out to many slaves.
- Round-robin arbitration, one grant per bus cycle; the grant is held for the whole CYC assertion, bursts (CTI/BTE) included.
- Sits between CPU/DMA masters and a wb_mux or a single slave.

Parameters:
- num_masters, 2, number of master ports (>=2)
- aw, 32, address width
- dw, 32, data width; sel width = dw/8
- mw, $clog2(num_masters) (minimum 1), internal index width, derived and not for override

Ports:
- wb_clk_i  in  1  bus clock
- wb_rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- wbm_adr_i  in  num_masters*aw  master addresses, master i at [i*aw+:aw]
- wbm_dat_i  in  num_masters*dw  master write data
- wbm_sel_i  in  num_masters*dw/8  byte selects
- wbm_we_i  in  num_masters  write enables
- wbm_cyc_i  in  num_masters  cycle requests
- wbm_stb_i  in  num_masters  strobes
- wbm_cti_i  in  num_masters*3  cycle type
- wbm_bte_i  in  num_masters*2  burst type
- wbm_dat_o  out  num_masters*dw  read data, broadcast to all masters
- wbm_ack_o  out  num_masters  ack, granted master only
- wbm_err_o  out  num_masters  err, granted master only
- wbm_rty_o  out  num_masters  rty, granted master only
- wbs_adr_o  out  aw  slave address
- wbs_dat_o  out  dw  slave write data
- wbs_sel_o  out  dw/8  slave byte selects
- wbs_we_o  out  1  slave write enable
- wbs_cyc_o  out  1  slave cycle
- wbs_stb_o  out  1  slave strobe
- wbs_cti_o  out  3  slave cycle type
- wbs_bte_o  out  2  slave burst type
- wbs_dat_i  in  dw  slave read data
- wbs_ack_i  in  1  slave ack
- wbs_err_i  in  1  slave err
- wbs_rty_i  in  1  slave rty

Behaviour:
- State: gnt_vld (1b), gnt_idx (mw), last_idx (mw).
- Reset (async): gnt_vld=0, gnt_idx=0, last_idx=num_masters-1, so master 0 has first priority after reset.
- Two states:
  - IDLE (gnt_vld=0): if any wbm_cyc_i, pick the first requester scanning last_idx+1, last_idx+2, ... mod num_masters. On the next edge: gnt_idx=pick, last_idx=pick, gnt_vld=1 (GRANTED). No request -> stay IDLE.
  - GRANTED: stays while wbm_cyc_i[gnt_idx]=1. When it is 0, go to IDLE on the next edge. Exactly one dead cycle between consecutive grants; arbitration restarts in IDLE.
- Latency: master raises CYC in cycle n -> wbs_cyc_o=1 in cycle n+1 (registered grant).
- Slave-side outputs are combinational from gnt_idx:
  - wbs_cyc_o = gnt_vld & wbm_cyc_i[gnt_idx]; wbs_stb_o = gnt_vld & wbm_stb_i[gnt_idx].
  - adr/dat/sel/we/cti/bte are muxed from gnt_idx unconditionally. In IDLE they are don't-care but still deterministic.
- Master-side outputs:
  - wbm_ack_o[i] = wbs_ack_i & gnt_vld & (gnt_idx==i); same rule for err and rty.
  - Non-granted masters never see ack/err/rty.
  - wbm_dat_o is wbs_dat_i replicated num_masters times.
- During reset all slave-side cyc/stb and all master acks are 0.
- Simultaneous requests are resolved purely by round-robin; no fixed priority except the reset state.
- A granted master dropping CYC in the same cycle another master raises CYC: release first; the new grant is in effect two edges later.
- A non-granted master with CYC held waits indefinitely; no starvation beyond num_masters-1 grants.
- Reset asserted mid-transfer: grant dropped immediately, wbs_cyc_o=0 asynchronously; the slave transaction is abandoned.
- wbs_ack_i while gnt_vld=0: ignored, routed nowhere.

Decomposition:
- No package. Index width is computed with a local constant function in the module.
- One sub-module, wb_rr_grant: combinational round-robin picker. Inputs: req[num_masters], last_idx. Outputs: pick_idx, pick_vld.
- The top holds the registers, the mux and the response routing.

Test Plan:
- Single master: after reset, master 1 does a write to 0x100 with data 0xDEADBEEF -> wbs_cyc_o rises 1 cycle after wbm_cyc_i[1]; slave sees adr 0x100, dat 0xDEADBEEF; wbm_ack_o=0b10 only.
- Contention: both masters raise CYC in the same cycle after reset -> master 0 granted first. After master 0 drops CYC, one IDLE cycle, then master 1 is granted.
- Fairness: 2 masters each issue 100 back-to-back single reads -> grants alternate 0,1,0,1 and each master completes exactly 100.
- Burst hold: master 0 issues a 4-beat incrementing burst (CTI=010, last beat 111) while master 1 requests -> master 1 is not granted until master 0 drops CYC; all 4 acks go to master 0.
- Err routing: slave asserts err on a master 1 access -> wbm_err_o=0b10; wbm_ack_o stays 0; master 0 sees nothing.
- Async reset mid-burst: assert wb_rst_i between clock edges while master 1 is granted -> wbs_cyc_o=0 before the next edge. After release, master 0 has priority (last_idx=num_masters-1).
